// File: rtl/eth_rx_frame_buf_if.sv
// Receive frame buffer bus: byte/verdict input from the RMII receive stage
// and the length-tagged read handshake toward the consumer.
interface eth_rx_frame_buf_if #(
  parameter int unsigned pADDR_WIDTH = 11
);
  logic                   Byte_Vld;
  logic [7:0]             Byte;
  logic                   Frame_End;
  logic                   Crc_Ok;
  logic                   Frm_Rdy;
  logic [pADDR_WIDTH-1:0] Frm_Len;
  logic                   Rd_En;
  logic [7:0]             Rd_Data;
  logic                   Rd_Vld;
  logic                   Rd_Last;
  logic [7:0]             Drop_Cnt;

  modport master (
    output Byte_Vld, Byte, Frame_End, Crc_Ok, Rd_En,
    input  Frm_Rdy, Frm_Len, Rd_Data, Rd_Vld, Rd_Last, Drop_Cnt
  );

  modport slave (
    input  Byte_Vld, Byte, Frame_End, Crc_Ok, Rd_En,
    output Frm_Rdy, Frm_Len, Rd_Data, Rd_Vld, Rd_Last, Drop_Cnt
  );
endinterface

// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: stores frames in a circular byte RAM, commits good
// frames with the FCS stripped, rolls back bad/overflowed/runt frames, and
// serves committed frames as length-tagged byte streams.
module eth_rx_frame_buf #(
  parameter int unsigned pADDR_WIDTH     = 11,
  parameter int unsigned pLEN_DEPTH_LOG2 = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  eth_rx_frame_buf_if.slave Bus
);
  localparam int unsigned cDepth    = 1 << pADDR_WIDTH;
  localparam int unsigned cLenDepth = 1 << pLEN_DEPTH_LOG2;

  typedef logic [pADDR_WIDTH-1:0]     ptr_t;
  typedef logic [pADDR_WIDTH:0]       cnt_t;
  typedef logic [pLEN_DEPTH_LOG2-1:0] lidx_t;
  typedef logic [pLEN_DEPTH_LOG2:0]   locc_t;

  localparam ptr_t  cPtrOne  = ptr_t'(1);
  localparam ptr_t  cPtrFcs  = ptr_t'(4);
  localparam cnt_t  cCntOne  = cnt_t'(1);
  localparam cnt_t  cCntFcs  = cnt_t'(4);
  localparam cnt_t  cCntMin  = cnt_t'(5);
  localparam cnt_t  cCntMax  = '1;
  localparam lidx_t cIdxOne  = lidx_t'(1);
  localparam locc_t cOccOne  = locc_t'(1);
  localparam locc_t cOccFull = locc_t'(cLenDepth);

  typedef enum logic [1:0] {sIdle, sWrite, sDrop} state_t;

  state_t     state;
  ptr_t       wrPtr, commitPtr, rdPtr, rdCnt;
  cnt_t       frmCnt;
  logic [7:0] dropCnt;
  logic [7:0] mem [cDepth];
  ptr_t       lenMem [cLenDepth];
  lidx_t      lenWrIdx, lenRdIdx;
  locc_t      lenOcc;
  logic [7:0] rdData;
  logic       rdVld, rdLast;

  logic full, lenFull, frmRdy, wrEn, ovf, dropEff, commit, rdAcc, rdEnd;
  ptr_t wrPtrEff, frmLen, lenPush;
  cnt_t cntEff;

  // Current-cycle byte is written and counted before any end-of-frame decision.
  always_comb begin
    full     = (wrPtr + cPtrOne) == rdPtr;
    lenFull  = lenOcc == cOccFull;
    frmRdy   = lenOcc != '0;
    frmLen   = frmRdy ? lenMem[lenRdIdx] : '0;
    wrEn     = 1'b0;
    ovf      = 1'b0;
    wrPtrEff = wrPtr;
    cntEff   = frmCnt;
    if (Bus.Byte_Vld && state != sDrop) begin
      if (full) begin
        ovf = 1'b1;
      end else begin
        wrEn     = 1'b1;
        wrPtrEff = wrPtr + cPtrOne;
        cntEff   = (frmCnt == cCntMax) ? frmCnt : frmCnt + cCntOne;
      end
    end
    dropEff = (state == sDrop) || ovf;
    commit  = Bus.Frame_End && Bus.Crc_Ok && !dropEff && (cntEff >= cCntMin) && !lenFull;
    lenPush = ptr_t'(cntEff - cCntFcs);
    rdAcc   = Bus.Rd_En && frmRdy;
    rdEnd   = rdAcc && (rdCnt == frmLen - cPtrOne);
  end

  // Storage arrays: frame bytes and committed frame lengths.
  always_ff @(posedge Clk) begin
    if (wrEn) mem[wrPtr] <= Bus.Byte;
    if (commit) lenMem[lenWrIdx] <= lenPush;
  end

  // Write FSM: accumulate a frame, then commit (pull back over the FCS) or roll back.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= sIdle;
      wrPtr     <= '0;
      commitPtr <= '0;
      frmCnt    <= '0;
      dropCnt   <= '0;
    end else if (Bus.Frame_End) begin
      state  <= sIdle;
      frmCnt <= '0;
      if (commit) begin
        wrPtr     <= wrPtrEff - cPtrFcs;
        commitPtr <= wrPtrEff - cPtrFcs;
      end else begin
        wrPtr <= commitPtr;
        if (dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
      end
    end else begin
      wrPtr  <= wrPtrEff;
      frmCnt <= cntEff;
      if (ovf)       state <= sDrop;
      else if (wrEn) state <= sWrite;
    end
  end

  // Read side and length FIFO bookkeeping; push and pop may coincide.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rdPtr    <= '0;
      rdCnt    <= '0;
      lenWrIdx <= '0;
      lenRdIdx <= '0;
      lenOcc   <= '0;
      rdData   <= '0;
      rdVld    <= 1'b0;
      rdLast   <= 1'b0;
    end else begin
      rdVld  <= rdAcc;
      rdLast <= rdEnd;
      if (rdAcc) begin
        rdData <= mem[rdPtr];
        rdPtr  <= rdPtr + cPtrOne;
        rdCnt  <= rdEnd ? '0 : rdCnt + cPtrOne;
      end
      if (commit) lenWrIdx <= lenWrIdx + cIdxOne;
      if (rdEnd)  lenRdIdx <= lenRdIdx + cIdxOne;
      case ({commit, rdEnd})
        2'b10:   lenOcc <= lenOcc + cOccOne;
        2'b01:   lenOcc <= lenOcc - cOccOne;
        default: lenOcc <= lenOcc;
      endcase
    end
  end

  assign Bus.Frm_Rdy  = frmRdy;
  assign Bus.Frm_Len  = frmLen;
  assign Bus.Rd_Data  = rdData;
  assign Bus.Rd_Vld   = rdVld;
  assign Bus.Rd_Last  = rdLast;
  assign Bus.Drop_Cnt = dropCnt;
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Bench for eth_rx_frame_buf: a 2 KiB instance and a 64-byte instance,
// expected read bytes queued as frames are sent and compared as they emerge.
module tb_eth_rx_frame_buf;
  logic Clk;
  logic Rst;

  eth_rx_frame_buf_if #(.pADDR_WIDTH(11)) bA ();
  eth_rx_frame_buf_if #(.pADDR_WIDTH(6))  bB ();

  eth_rx_frame_buf #(.pADDR_WIDTH(11), .pLEN_DEPTH_LOG2(2)) dutA (.Clk(Clk), .Rst(Rst), .Bus(bA));
  eth_rx_frame_buf #(.pADDR_WIDTH(6),  .pLEN_DEPTH_LOG2(2)) dutB (.Clk(Clk), .Rst(Rst), .Bus(bB));

  int nChecks = 0;
  int nErrors = 0;
  int expDropA = 0;
  int expDropB = 0;
  logic [8:0] qA[$];
  logic [8:0] qB[$];

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input int sel, input logic vld, input logic [7:0] b, input logic fe, input logic crc);
    if (sel == 0) begin
      bA.Byte_Vld = vld; bA.Byte = b; bA.Frame_End = fe; bA.Crc_Ok = crc;
    end else begin
      bB.Byte_Vld = vld; bB.Byte = b; bB.Frame_End = fe; bB.Crc_Ok = crc;
    end
  endtask

  task automatic setRd(input int sel, input logic en);
    if (sel == 0) bA.Rd_En = en;
    else          bB.Rd_En = en;
  endtask

  task automatic pushExp(input int sel, input logic [8:0] v);
    if (sel == 0) qA.push_back(v);
    else          qB.push_back(v);
  endtask

  // Sends n bytes base, base+1, ...; expected payload is queued if a commit is predicted.
  task automatic sendFrame(input int sel, input int n, input logic crc, input logic [7:0] base, input bit expCommit);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      @(negedge Clk);
      setIn(sel, 1'b1, b, 1'b0, 1'b0);
      if (expCommit && i < n - 4) pushExp(sel, {(i == n - 5), b});
    end
    @(negedge Clk);
    setIn(sel, 1'b0, 8'h00, 1'b1, crc);
    @(negedge Clk);
    setIn(sel, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic readCycles(input int sel, input int delay, input int n);
    repeat (delay) @(negedge Clk);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      setRd(sel, 1'b1);
    end
    @(negedge Clk);
    setRd(sel, 1'b0);
  endtask

  task automatic drained(input int sel, input string tag);
    @(negedge Clk);
    if (sel == 0) checkVal(tag, 32'(qA.size()), 32'd0);
    else          checkVal(tag, 32'(qB.size()), 32'd0);
  endtask

  // Scoreboard monitors: every valid read byte must match the queue head.
  always @(negedge Clk) begin
    logic [8:0] e;
    if (bA.Rd_Vld) begin
      if (qA.size() == 0) checkVal("A_unexpected_rd", 32'(bA.Rd_Vld), 32'd0);
      else begin
        e = qA.pop_front();
        checkVal("A_rd_data", 32'(bA.Rd_Data), 32'(e[7:0]));
        checkVal("A_rd_last", 32'(bA.Rd_Last), 32'(e[8]));
      end
    end
  end

  always @(negedge Clk) begin
    logic [8:0] e;
    if (bB.Rd_Vld) begin
      if (qB.size() == 0) checkVal("B_unexpected_rd", 32'(bB.Rd_Vld), 32'd0);
      else begin
        e = qB.pop_front();
        checkVal("B_rd_data", 32'(bB.Rd_Data), 32'(e[7:0]));
        checkVal("B_rd_last", 32'(bB.Rd_Last), 32'(e[8]));
      end
    end
  end

  initial begin
    Rst = 1'b1;
    setIn(0, 1'b0, 8'h00, 1'b0, 1'b0);
    setIn(1, 1'b0, 8'h00, 1'b0, 1'b0);
    setRd(0, 1'b0);
    setRd(1, 1'b0);
    repeat (3) @(negedge Clk);
    checkVal("A_rst_frm_rdy", 32'(bA.Frm_Rdy), 32'd0);
    checkVal("A_rst_frm_len", 32'(bA.Frm_Len), 32'd0);
    checkVal("A_rst_rd_data", 32'(bA.Rd_Data), 32'd0);
    checkVal("A_rst_rd_vld", 32'(bA.Rd_Vld), 32'd0);
    checkVal("A_rst_rd_last", 32'(bA.Rd_Last), 32'd0);
    checkVal("A_rst_drop", 32'(bA.Drop_Cnt), 32'd0);
    checkVal("B_rst_frm_rdy", 32'(bB.Frm_Rdy), 32'd0);
    checkVal("B_rst_drop", 32'(bB.Drop_Cnt), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // 64-byte good frame
    sendFrame(0, 64, 1'b1, 8'h00, 1'b1);
    checkVal("T1_frm_rdy", 32'(bA.Frm_Rdy), 32'd1);
    checkVal("T1_frm_len", 32'(bA.Frm_Len), 32'd60);
    readCycles(0, 0, 64);
    drained(0, "T1_drained");
    checkVal("T1_frm_rdy_after", 32'(bA.Frm_Rdy), 32'd0);

    // Bad CRC frame rolled back, then a 70-byte good frame
    sendFrame(0, 64, 1'b0, 8'h40, 1'b0);
    expDropA++;
    checkVal("T2_drop", 32'(bA.Drop_Cnt), 32'(expDropA));
    checkVal("T2_frm_rdy", 32'(bA.Frm_Rdy), 32'd0);
    sendFrame(0, 70, 1'b1, 8'h80, 1'b1);
    checkVal("T2_frm_len", 32'(bA.Frm_Len), 32'd66);
    readCycles(0, 0, 70);
    drained(0, "T2_drained");

    // Overflow on the 64-byte RAM
    sendFrame(1, 100, 1'b1, 8'h00, 1'b0);
    expDropB++;
    checkVal("T3_drop", 32'(bB.Drop_Cnt), 32'(expDropB));
    checkVal("T3_frm_rdy", 32'(bB.Frm_Rdy), 32'd0);
    sendFrame(1, 20, 1'b1, 8'h50, 1'b1);
    checkVal("T3_frm_len", 32'(bB.Frm_Len), 32'd16);
    readCycles(1, 0, 16);
    drained(1, "T3_drained");

    // Length FIFO full: fifth frame dropped, sixth commits after one read
    for (int f = 0; f < 5; f++) begin
      sendFrame(0, 10, 1'b1, 8'(8'h20 + 8'(f * 16)), f < 4);
      checkVal("T4_frm_len", 32'(bA.Frm_Len), 32'd6);
    end
    expDropA++;
    checkVal("T4_drop", 32'(bA.Drop_Cnt), 32'(expDropA));
    readCycles(0, 0, 6);
    sendFrame(0, 10, 1'b1, 8'hA5, 1'b1);
    checkVal("T4_drop_after", 32'(bA.Drop_Cnt), 32'(expDropA));
    checkVal("T4_frm_len_after", 32'(bA.Frm_Len), 32'd6);
    readCycles(0, 0, 30);
    drained(0, "T4_drained");
    checkVal("T4_frm_rdy_after", 32'(bA.Frm_Rdy), 32'd0);

    // Wrap-around with concurrent read; Rd_Last pop lands on the commit push
    sendFrame(1, 30, 1'b1, 8'h60, 1'b1);
    checkVal("T5_frm_len1", 32'(bB.Frm_Len), 32'd26);
    fork
      sendFrame(1, 30, 1'b1, 8'h90, 1'b1);
      readCycles(1, 5, 26);
    join
    checkVal("T5_frm_rdy_swap", 32'(bB.Frm_Rdy), 32'd1);
    checkVal("T5_frm_len_swap", 32'(bB.Frm_Len), 32'd26);
    fork
      sendFrame(1, 30, 1'b1, 8'hB0, 1'b1);
      readCycles(1, 0, 40);
    join
    readCycles(1, 0, 30);
    drained(1, "T5_drained");
    checkVal("T5_frm_rdy_after", 32'(bB.Frm_Rdy), 32'd0);
    checkVal("T5_drop", 32'(bB.Drop_Cnt), 32'(expDropB));

    // Reset mid-frame and mid-read
    sendFrame(0, 20, 1'b1, 8'hC0, 1'b1);
    checkVal("T6_pre_len", 32'(bA.Frm_Len), 32'd16);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      setIn(0, 1'b1, 8'(8'hE0 + 8'(i)), 1'b0, 1'b0);
      setRd(0, 1'b1);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checkVal("T6_frm_rdy", 32'(bA.Frm_Rdy), 32'd0);
    checkVal("T6_frm_len", 32'(bA.Frm_Len), 32'd0);
    checkVal("T6_rd_data", 32'(bA.Rd_Data), 32'd0);
    checkVal("T6_rd_vld", 32'(bA.Rd_Vld), 32'd0);
    checkVal("T6_rd_last", 32'(bA.Rd_Last), 32'd0);
    checkVal("T6_drop", 32'(bA.Drop_Cnt), 32'd0);
    Rst = 1'b0;
    setIn(0, 1'b0, 8'h00, 1'b0, 1'b0);
    setRd(0, 1'b0);
    qA.delete();
    expDropA = 0;
    sendFrame(0, 64, 1'b1, 8'h10, 1'b1);
    checkVal("T6_post_len", 32'(bA.Frm_Len), 32'd60);
    readCycles(0, 0, 64);
    drained(0, "T6_drained");
    checkVal("T6_post_drop", 32'(bA.Drop_Cnt), 32'(expDropA));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
